byte_fetch_unit: RTL



---
 rtl/byte_fetch_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/byte_fetch_unit.sv
// Fetches four bytes at pc, assembles them little-endian into instr, and hands them off with valid/ready.
// Optional `FETCH_BOUNDS_CHECK_EN: out-of-range fetches park in FAULT instead of issuing reads.
module byte_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'd3,
   parameter int unsigned MEM_BYTES = 3000
) (
   input  logic        clk_in,
   input  logic        reset,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [7:0]  mem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   typedef enum logic [1:0] {ST_FETCH, ST_HOLD, ST_FAULT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  k_q, k_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        oob;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [31:0] FETCH_LIMIT = 32'(MEM_BYTES - 4);
   assign oob = (pc_q > FETCH_LIMIT);
`else
   assign oob = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         ST_FETCH: begin
            if (k_q == 3'd0 && oob) begin
               state_d = ST_FAULT;
            end else begin
               // Byte read at k-1 arrives at k; slot index (k-1) mod 4 maps k=4 onto b3.
               if (k_q != 3'd0)
                  instr_d[{k_q[1:0] - 2'd1, 3'b000} +: 8] = mem_rdata;
               if (k_q == 3'd4) begin
                  state_d = ST_HOLD;
                  k_d     = 3'd0;
               end else begin
                  k_d = k_q + 3'd1;
               end
            end
         end
         ST_HOLD: begin
            if (instr_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = ST_FETCH;
               k_d     = 3'd0;
            end
         end
         ST_FAULT: ;
         default: begin
            state_d = ST_FETCH;
            k_d     = 3'd0;
         end
      endcase
      // Redirect overrides everything, including a coincident handshake's pc + 4.
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         state_d = ST_FETCH;
         k_d     = 3'd0;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q <= ST_FETCH;
         k_q     <= 3'd0;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   // Gating with reset keeps the read strobe low while reset is held.
   assign mem_rd      = !reset && (state_q == ST_FETCH) && (k_q < 3'd4) && !(k_q == 3'd0 && oob);
   assign mem_addr    = pc_q + 32'(k_q);
   assign instr       = instr_q;
   assign instr_pc    = pc_q;
   assign instr_valid = (state_q == ST_HOLD);
`ifdef FETCH_BOUNDS_CHECK_EN
   assign fetch_fault = (state_q == ST_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

endmodule
